// File: rtl/ir_loader_pkg.sv
// ir_loader_pkg -- shared types and constants for the serial instruction loader.
//
// Contents:
//   ir_state_t  frame-level loader states
//   rx_state_t  UART receiver bit-level states
//   HDR_BYTE    frame header byte
//   MAX_WORDS   largest word count a frame may carry (size of instruction RAM)
//   ADDR_W, DATA_W, CNT_W  instruction RAM address / data widths and word counter width
//   is_active() true for states that belong to a frame in progress
package ir_loader_pkg;

    localparam logic [7:0] HDR_BYTE  = 8'hA5;
    localparam int         MAX_WORDS = 4096;
    localparam int         ADDR_W    = 12;
    localparam int         DATA_W    = 16;
    localparam int         CNT_W     = 13;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_HI = 3'd1,
        CNT_LO = 3'd2,
        DAT_HI = 3'd3,
        DAT_LO = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } ir_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    function automatic logic is_active(input ir_state_t s);
        return !(s == IDLE || s == DONE || s == ERR);
    endfunction

endpackage

// File: rtl/ir_loader_uart_rx.sv
// uart_rx -- 8N1 UART receiver with input synchronizer.
//
// Parameters:
//   DIV         use_clock cycles per serial bit (>= 2)
// Ports:
//   use_clock   system clock, rising edge
//   n_reset     synchronous active-low reset
//   rxd         asynchronous serial line, idle high
//   rx_byte     received byte, valid while byte_valid is high
//   byte_valid  one-cycle strobe: a byte with a good stop bit arrived
//   frame_err   one-cycle strobe: a byte arrived with stop bit 0 (byte discarded)
module uart_rx
    import ir_loader_pkg::*;
#(
    parameter int DIV = 520
) (
    input  logic       use_clock,
    input  logic       n_reset,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;

    // rxd_p0/rxd_p1 form the synchronizer; rxd_p2 is the previous synchronized
    // sample used for falling-edge detection.
    logic rxd_p0, rxd_p1, rxd_p2;

    rx_state_t      rx_st, rx_nxt;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           cnt_clr, samp, bv_nxt, fe_nxt, fall;

    assign fall    = rxd_p2 && !rxd_p1;
    assign rx_byte = shreg;

    always_ff @(posedge use_clock) begin
        if (!n_reset) begin
            rxd_p0     <= 1'b1;
            rxd_p1     <= 1'b1;
            rxd_p2     <= 1'b1;
            rx_st      <= R_IDLE;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // stage p0 -> p1 -> p2: metastability filter, then edge history
            rxd_p0     <= rxd;
            rxd_p1     <= rxd_p0;
            rxd_p2     <= rxd_p1;
            rx_st      <= rx_nxt;
            byte_valid <= bv_nxt;
            frame_err  <= fe_nxt;
        end
    end

    // Bit timer and shifter carry no reset: the timer is cleared on every
    // start edge and the shifter is fully rewritten before each byte_valid.
    always_ff @(posedge use_clock) begin
        cnt <= cnt_clr ? '0 : cnt + CW'(1);
        if (rx_st == R_START && rx_nxt == R_DATA)
            bit_idx <= 3'd0;
        else if (samp)
            bit_idx <= bit_idx + 3'd1;
        if (samp)
            shreg <= {rxd_p1, shreg[7:1]};
    end

    always_comb begin
        rx_nxt  = rx_st;
        cnt_clr = 1'b0;
        samp    = 1'b0;
        bv_nxt  = 1'b0;
        fe_nxt  = 1'b0;
        case (rx_st)
            R_IDLE: begin
                if (fall) begin
                    rx_nxt  = R_START;
                    cnt_clr = 1'b1;
                end
            end
            R_START: begin
                // Half a bit after the edge: a line that is high again was a
                // glitch, not a start bit.
                if (cnt == CW'(HALF - 1)) begin
                    rx_nxt  = rxd_p1 ? R_IDLE : R_DATA;
                    cnt_clr = 1'b1;
                end
            end
            R_DATA: begin
                if (cnt == CW'(DIV - 1)) begin
                    samp    = 1'b1;
                    cnt_clr = 1'b1;
                    if (bit_idx == 3'd7)
                        rx_nxt = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt == CW'(DIV - 1)) begin
                    bv_nxt = rxd_p1;
                    fe_nxt = !rxd_p1;
                    rx_nxt = R_IDLE;
                end
            end
            default: rx_nxt = R_IDLE;
        endcase
    end

endmodule

// File: rtl/ir_loader.sv
// ir_loader -- receives an instruction image over a UART and writes it into
// instruction RAM while holding the CPU in reset.
//
// Frame: A5, N[15:8], N[7:0], N x (word[15:8], word[7:0]) [, checksum].
// The checksum byte (mod-256 sum of the 2N data bytes) is expected only when
// the macro IR_LOADER_CSUM_EN is defined; otherwise the last data word ends
// the frame.
//
// Parameters:
//   CLK_HZ      use_clock frequency in Hz
//   BAUD        serial bit rate (bit period = CLK_HZ/BAUD cycles, truncated)
//   TIMEOUT     max idle cycles between bytes inside a frame
// Ports:
//   use_clock   system clock, rising edge
//   n_reset     synchronous active-low reset
//   rxd         asynchronous UART line, idle high, 8N1
//   ir_addr     instruction RAM write address
//   ir_data     instruction RAM write data
//   ir_wren     one-cycle RAM write strobe
//   cpu_hold    high while a frame is in progress
//   load_done   sticky: last frame completed
//   err         sticky: last frame aborted
//   word_count  words written by the current or last frame
module ir_loader
    import ir_loader_pkg::*;
#(
    parameter int CLK_HZ  = 60000000,
    parameter int BAUD    = 115200,
    parameter int TIMEOUT = 16777215
) (
    input  logic              use_clock,
    input  logic              n_reset,
    input  logic              rxd,
    output logic [ADDR_W-1:0] ir_addr,
    output logic [DATA_W-1:0] ir_data,
    output logic              ir_wren,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              err,
    output logic [CNT_W-1:0]  word_count
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [7:0] rx_byte;
    logic       rx_vld, rx_ferr;

    uart_rx #(.DIV(DIV)) u_rx (
        .use_clock  (use_clock),
        .n_reset    (n_reset),
        .rxd        (rxd),
        .rx_byte    (rx_byte),
        .byte_valid (rx_vld),
        .frame_err  (rx_ferr)
    );

    ir_state_t         state, state_nxt;
    logic [7:0]        cnt_hi, dat_hi;
    logic [CNT_W-1:0]  n_words;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [15:0]       n_req;
    logic              tmo_hit, hdr_ok, wr_req, last_word, len_bad;
`ifdef IR_LOADER_CSUM_EN
    logic [7:0]        csum;
`endif

    assign n_req   = {cnt_hi, rx_byte};
    assign len_bad = (n_req == 16'd0) || (n_req > 16'(MAX_WORDS));
    // word_count is already updated for the previous word here: consecutive
    // bytes are at least a full character time apart.
    assign last_word = (word_count + CNT_W'(1)) == n_words;
    assign tmo_hit   = tmo_cnt == TMO_W'(TIMEOUT - 1);

    assign cpu_hold  = is_active(state);
    assign load_done = (state == DONE);
    assign err       = (state == ERR);

    always_comb begin
        state_nxt = state;
        hdr_ok    = 1'b0;
        wr_req    = 1'b0;
        if (is_active(state) && rx_ferr) begin
            state_nxt = ERR;
        end else if (rx_vld) begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (rx_byte == HDR_BYTE) begin
                        state_nxt = CNT_HI;
                        hdr_ok    = 1'b1;
                    end
                end
                CNT_HI: state_nxt = CNT_LO;
                CNT_LO: state_nxt = len_bad ? ERR : DAT_HI;
                DAT_HI: state_nxt = DAT_LO;
                DAT_LO: begin
                    wr_req = 1'b1;
`ifdef IR_LOADER_CSUM_EN
                    state_nxt = last_word ? CSUM : DAT_HI;
`else
                    state_nxt = last_word ? DONE : DAT_HI;
`endif
                end
`ifdef IR_LOADER_CSUM_EN
                CSUM: state_nxt = (rx_byte == csum) ? DONE : ERR;
`endif
                default: state_nxt = IDLE;
            endcase
        end else if (is_active(state) && tmo_hit) begin
            state_nxt = ERR;
        end
    end

    always_ff @(posedge use_clock) begin
        if (!n_reset) begin
            state      <= IDLE;
            ir_addr    <= '0;
            ir_data    <= '0;
            ir_wren    <= 1'b0;
            word_count <= '0;
            tmo_cnt    <= '0;
        end else begin
            state   <= state_nxt;
            ir_wren <= wr_req;
            if (wr_req)
                ir_data <= {dat_hi, rx_byte};
            if (hdr_ok) begin
                word_count <= '0;
            end else if (ir_wren) begin
                // 4095 -> 0 only after the 4096th word, which ends the frame
                word_count <= word_count + CNT_W'(1);
                ir_addr    <= ir_addr + ADDR_W'(1);
            end
            if (state == CNT_LO && state_nxt == DAT_HI)
                ir_addr <= '0;
            if (!is_active(state) || rx_vld || rx_ferr)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Frame fields; no reset needed, each is written before it is read.
    always_ff @(posedge use_clock) begin
        if (rx_vld) begin
            case (state)
                CNT_HI:  cnt_hi  <= rx_byte;
                CNT_LO:  n_words <= n_req[CNT_W-1:0];
                DAT_HI:  dat_hi  <= rx_byte;
                default: ;
            endcase
        end
`ifdef IR_LOADER_CSUM_EN
        if (hdr_ok)
            csum <= 8'd0;
        else if (rx_vld && (state == DAT_HI || state == DAT_LO))
            csum <= csum + rx_byte;
`endif
    end

endmodule

// File: tb/tb_ir_loader.sv
// tb_ir_loader -- directed bench for ir_loader (CLK_HZ=1000, BAUD=100, TIMEOUT=200).
// Expected values are written out by hand next to each stimulus.
module tb_ir_loader;

    localparam int CLK_HZ  = 1000;
    localparam int BAUD    = 100;
    localparam int TIMEOUT = 200;
    localparam int DIV     = CLK_HZ / BAUD;

    logic        use_clock = 1'b0;
    logic        n_reset   = 1'b0;
    logic        rxd       = 1'b1;
    logic [11:0] ir_addr;
    logic [15:0] ir_data;
    logic        ir_wren;
    logic        cpu_hold;
    logic        load_done;
    logic        err;
    logic [12:0] word_count;

    int n_cmp = 0;
    int n_bad = 0;
    int base;

    logic [11:0] wa_q[$];
    logic [15:0] wd_q[$];

    always #5 use_clock = ~use_clock;

    ir_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT(TIMEOUT)) dut (
        .use_clock  (use_clock),
        .n_reset    (n_reset),
        .rxd        (rxd),
        .ir_addr    (ir_addr),
        .ir_data    (ir_data),
        .ir_wren    (ir_wren),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .err        (err),
        .word_count (word_count)
    );

    // Log every RAM write, sampled away from the active edge.
    always @(negedge use_clock) begin
        if (ir_wren) begin
            wa_q.push_back(ir_addr);
            wd_q.push_back(ir_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge use_clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        idle(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(DIV);
        end
        rxd = stop_bit;
        idle(DIV);
        rxd = 1'b1;
    endtask

    task automatic sb(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [11:0] a, input logic [15:0] d);
        if (idx < wa_q.size()) begin
            chk({tag, "_addr"}, 32'(wa_q[idx]), 32'(a));
            chk({tag, "_data"}, 32'(wd_q[idx]), 32'(d));
        end else begin
            chk({tag, "_present"}, 32'(wa_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic chk_flags(input string tag, input logic ld, input logic er, input logic hold);
        chk({tag, "_load_done"}, 32'(load_done), 32'(ld));
        chk({tag, "_err"},       32'(err),       32'(er));
        chk({tag, "_cpu_hold"},  32'(cpu_hold),  32'(hold));
    endtask

    initial begin
        // Reset state
        idle(3);
        chk("rst_addr",  32'(ir_addr),    32'd0);
        chk("rst_data",  32'(ir_data),    32'd0);
        chk("rst_wren",  32'(ir_wren),    32'd0);
        chk("rst_wc",    32'(word_count), 32'd0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
        n_reset = 1'b1;
        idle(5);

        // Two-word frame; checksum 12+34+AB+CD = 0x1BE -> BE (ignored when
        // the checksum option is off, since the frame is already done)
        base = wa_q.size();
        sb(8'hA5); sb(8'h00); sb(8'h02);
        chk_flags("f1_mid", 1'b0, 1'b0, 1'b1);
        sb(8'h12); sb(8'h34); sb(8'hAB); sb(8'hCD); sb(8'hBE);
        idle(5);
        chk("f1_nwr", 32'(wa_q.size() - base), 32'd2);
        chk_wr("f1_w0", base,     12'd0, 16'h1234);
        chk_wr("f1_w1", base + 1, 12'd1, 16'hABCD);
        chk("f1_wc", 32'(word_count), 32'd2);
        chk_flags("f1_end", 1'b1, 1'b0, 1'b0);

        // One word, checksum byte FF (correct would be 00+01 = 01)
        base = wa_q.size();
        sb(8'hA5); sb(8'h00); sb(8'h01); sb(8'h00); sb(8'h01); sb(8'hFF);
        idle(5);
        chk("f2_nwr", 32'(wa_q.size() - base), 32'd1);
        chk_wr("f2_w0", base, 12'd0, 16'h0001);
        chk("f2_wc", 32'(word_count), 32'd1);
`ifdef IR_LOADER_CSUM_EN
        chk_flags("f2_end", 1'b0, 1'b1, 1'b0);
`else
        chk_flags("f2_end", 1'b1, 1'b0, 1'b0);
`endif

        // N = 0x1001 = 4097 -> ERR, no write; then N = 0 -> ERR
        base = wa_q.size();
        sb(8'hA5); sb(8'h10); sb(8'h01);
        idle(5);
        chk_flags("n4097", 1'b0, 1'b1, 1'b0);
        chk("n4097_nwr", 32'(wa_q.size() - base), 32'd0);
        chk("n4097_wc", 32'(word_count), 32'd0);
        sb(8'hA5); sb(8'h00); sb(8'h00);
        idle(5);
        chk_flags("n0", 1'b0, 1'b1, 1'b0);
        chk("n0_nwr", 32'(wa_q.size() - base), 32'd0);

        // Inter-byte timeout: stop after the first data byte
        sb(8'hA5); sb(8'h00); sb(8'h02); sb(8'h12);
        idle(150);
        chk_flags("tmo_150", 1'b0, 1'b0, 1'b1);
        idle(100);
        chk_flags("tmo_250", 1'b0, 1'b1, 1'b0);
        base = wa_q.size();
        sb(8'hA5); sb(8'h00); sb(8'h02);
        sb(8'h12); sb(8'h34); sb(8'hAB); sb(8'hCD); sb(8'hBE);
        idle(5);
        chk_flags("tmo_recover", 1'b1, 1'b0, 1'b0);
        chk("tmo_recover_nwr", 32'(wa_q.size() - base), 32'd2);

        // Framing error inside a frame
        base = wa_q.size();
        sb(8'hA5); sb(8'h00); sb(8'h02);
        send_byte(8'h12, 1'b0);
        idle(2 * DIV);
        chk_flags("ferr", 1'b0, 1'b1, 1'b0);
        chk("ferr_nwr", 32'(wa_q.size() - base), 32'd0);

        // 3-cycle low glitch between bytes must not produce a byte
        base = wa_q.size();
        sb(8'hA5); sb(8'h00); sb(8'h01);
        idle(10);
        rxd = 1'b0;
        idle(3);
        rxd = 1'b1;
        idle(20);
        sb(8'h00); sb(8'h01); sb(8'h01);
        idle(5);
        chk("glitch_nwr", 32'(wa_q.size() - base), 32'd1);
        chk_wr("glitch_w0", base, 12'd0, 16'h0001);
        chk("glitch_wc", 32'(word_count), 32'd1);
        chk_flags("glitch", 1'b1, 1'b0, 1'b0);

        // Reset in DAT_LO, partway through the low byte of word 1
        base = wa_q.size();
        sb(8'hA5); sb(8'h00); sb(8'h02); sb(8'h12); sb(8'h34); sb(8'hAB);
        chk("rdl_wc_before", 32'(word_count), 32'd1);
        rxd = 1'b0;
        idle(DIV);
        rxd = 1'b1;
        idle(DIV);
        rxd = 1'b0;
        idle(5);
        n_reset = 1'b0;
        rxd     = 1'b1;
        idle(2);
        chk("rdl_addr", 32'(ir_addr),    32'd0);
        chk("rdl_data", 32'(ir_data),    32'd0);
        chk("rdl_wren", 32'(ir_wren),    32'd0);
        chk("rdl_wc",   32'(word_count), 32'd0);
        chk_flags("rdl", 1'b0, 1'b0, 1'b0);
        n_reset = 1'b1;
        idle(150);
        chk("rdl_nwr", 32'(wa_q.size() - base), 32'd1);
        chk_flags("rdl_after", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
